// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall, branch/flush redirect and a
// one-entry buffer that holds a branch resolved while fetch is stalled.
module pc_unit #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter int STEP = 4,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall_en,
  input  logic               branch_flag,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_target,
  output logic               chip_en,
  output logic [PC_W-1:0]    pc,
  output logic               redirect_pending,
  output logic [PC_W-1:0]    pending_target
);
  localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);
  logic            stalled;
  logic            unused_stall;
  logic [PC_W-1:0] pc_nxt;
  logic            pend_nxt;
  logic [PC_W-1:0] ptgt_nxt;
  assign stalled      = stall_en[0];
  assign unused_stall = ^stall_en;
  // Flush beats everything; a live branch beats the buffered one; stalls defer branches.
  always_comb begin
    pc_nxt   = !chip_en                      ? RESET_VECTOR   :
               flush                         ? flush_target   :
               (!stalled && branch_flag)     ? branch_target  :
               (!stalled && redirect_pending) ? pending_target :
               stalled                       ? pc             : pc + STEP_V;
    pend_nxt = chip_en && !flush && stalled && (redirect_pending || branch_flag);
    ptgt_nxt = (chip_en && !flush && stalled && branch_flag) ? branch_target : pending_target;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      chip_en          <= 1'b0;
      pc               <= RESET_VECTOR;
      redirect_pending <= 1'b0;
      pending_target   <= '0;
    end else begin
      chip_en          <= 1'b1;
      pc               <= pc_nxt;
      redirect_pending <= pend_nxt;
      pending_target   <= ptgt_nxt;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit (32-bit and 16-bit builds)
// against a behavioural model of the fetch-address rules.
module tb_pc_unit;
  localparam logic [31:0] RV = 32'hBFC00000;
  logic        clk = 0;
  logic        reset = 1;
  logic [5:0]  stall_en = '0;
  logic        branch_flag = 0;
  logic [31:0] branch_target = '0;
  logic        flush = 0;
  logic [31:0] flush_target = '0;
  logic        ce_a, rp_a, ce_b, rp_b;
  logic [31:0] pc_a, pt_a;
  logic [15:0] pc_b, pt_b;
  int total = 0;
  int bad = 0;
  logic        m_en[2], m_pend[2];
  logic [31:0] m_pc[2], m_ptgt[2];
  logic [31:0] mask[2] = '{32'hFFFFFFFF, 32'h0000FFFF};
  logic [31:0] rv[2] = '{32'hBFC00000, 32'h0};

  pc_unit #(.PC_W(32), .RESET_VECTOR(RV), .STEP(4), .STALL_W(6)) dut_a (
    .clk(clk), .reset(reset), .stall_en(stall_en), .branch_flag(branch_flag),
    .branch_target(branch_target), .flush(flush), .flush_target(flush_target),
    .chip_en(ce_a), .pc(pc_a), .redirect_pending(rp_a), .pending_target(pt_a));
  pc_unit #(.PC_W(16), .RESET_VECTOR(16'h0), .STEP(4), .STALL_W(6)) dut_b (
    .clk(clk), .reset(reset), .stall_en(stall_en), .branch_flag(branch_flag),
    .branch_target(branch_target[15:0]), .flush(flush), .flush_target(flush_target[15:0]),
    .chip_en(ce_b), .pc(pc_b), .redirect_pending(rp_b), .pending_target(pt_b));

  always #5 clk = ~clk;

  // Advance one edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_en[d] = 0; m_pc[d] = rv[d]; m_pend[d] = 0; m_ptgt[d] = 0;
      end else if (!m_en[d]) begin
        m_en[d] = 1; m_pc[d] = rv[d]; m_pend[d] = 0;
      end else if (flush) begin
        m_pc[d] = flush_target & mask[d]; m_pend[d] = 0;
      end else if (!stall_en[0]) begin
        if (branch_flag) m_pc[d] = branch_target & mask[d];
        else if (m_pend[d]) m_pc[d] = m_ptgt[d];
        else m_pc[d] = (m_pc[d] + 4) & mask[d];
        m_pend[d] = 0;
      end else if (branch_flag) begin
        m_pend[d] = 1; m_ptgt[d] = branch_target & mask[d];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    stall_en = '0; branch_flag = 0; flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; quiet();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ce_a !== 1'b0 || pc_a !== RV) begin
        bad++; $display("FAIL reset_hold ce=%b pc=%h expected ce=0 pc=%h", ce_a, pc_a, RV);
      end
    end
    reset = 0;
    tick();
    total++;
    if (ce_a !== 1'b1 || pc_a !== RV || rp_a !== 1'b0) begin
      bad++; $display("FAIL reset_release ce=%b pc=%h rp=%b expected ce=1 pc=%h rp=0", ce_a, pc_a, rp_a, RV);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++;
      if (pc_a !== RV + 32'(4 * i)) begin
        bad++; $display("FAIL startup_inc pc=%h expected %h", pc_a, RV + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    branch_flag = 1; branch_target = 32'h100;
    tick();
    quiet();
    stall_en = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pc_a !== 32'h100) begin
        bad++; $display("FAIL stall_hold pc=%h expected 00000100", pc_a);
      end
    end
    stall_en = '0;
    tick();
    total++;
    if (pc_a !== 32'h104) begin
      bad++; $display("FAIL stall_release pc=%h expected 00000104", pc_a);
    end
    stall_en = 6'b111110;
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++;
      if (pc_a !== 32'h104 + 32'(4 * i)) begin
        bad++; $display("FAIL upper_stall_ignored pc=%h expected %h", pc_a, 32'h104 + 32'(4 * i));
      end
    end
    quiet();
  endtask

  task automatic test_branch();
    branch_flag = 1; branch_target = 32'h2000;
    tick();
    total++;
    if (pc_a !== 32'h2000 || rp_a !== 1'b0) begin
      bad++; $display("FAIL branch_run pc=%h rp=%b expected 00002000 0", pc_a, rp_a);
    end
    quiet();
    tick();
    stall_en = 6'b000001; branch_flag = 1; branch_target = 32'h2000;
    tick();
    total++;
    if (pc_a !== 32'h2004 || rp_a !== 1'b1 || pt_a !== 32'h2000) begin
      bad++; $display("FAIL branch_buffer pc=%h rp=%b pt=%h expected 00002004 1 00002000", pc_a, rp_a, pt_a);
    end
    branch_flag = 0;
    tick();
    total++;
    if (pc_a !== 32'h2004 || rp_a !== 1'b1) begin
      bad++; $display("FAIL branch_buffer_hold pc=%h rp=%b expected 00002004 1", pc_a, rp_a);
    end
    stall_en = '0;
    tick();
    total++;
    if (pc_a !== 32'h2000 || rp_a !== 1'b0) begin
      bad++; $display("FAIL branch_deferred pc=%h rp=%b expected 00002000 0", pc_a, rp_a);
    end
    stall_en = 6'b000001; branch_flag = 1; branch_target = 32'h3000;
    tick();
    branch_target = 32'h4000;
    tick();
    total++;
    if (pt_a !== 32'h4000 || rp_a !== 1'b1) begin
      bad++; $display("FAIL branch_overwrite pt=%h rp=%b expected 00004000 1", pt_a, rp_a);
    end
    quiet();
    tick();
    total++;
    if (pc_a !== 32'h4000) begin
      bad++; $display("FAIL branch_newest pc=%h expected 00004000", pc_a);
    end
  endtask

  task automatic test_flush();
    stall_en = 6'b000001; branch_flag = 1; branch_target = 32'h2000;
    tick();
    branch_flag = 0; flush = 1; flush_target = 32'h80;
    tick();
    total++;
    if (pc_a !== 32'h80 || rp_a !== 1'b0) begin
      bad++; $display("FAIL flush_over_stall pc=%h rp=%b expected 00000080 0", pc_a, rp_a);
    end
    flush = 1; branch_flag = 1; flush_target = 32'h500; branch_target = 32'h600;
    tick();
    total++;
    if (pc_a !== 32'h500 || rp_a !== 1'b0) begin
      bad++; $display("FAIL flush_branch_stalled pc=%h rp=%b expected 00000500 0", pc_a, rp_a);
    end
    stall_en = '0; flush_target = 32'h700; branch_target = 32'h800;
    tick();
    total++;
    if (pc_a !== 32'h700 || rp_a !== 1'b0) begin
      bad++; $display("FAIL flush_branch_run pc=%h rp=%b expected 00000700 0", pc_a, rp_a);
    end
    quiet();
    tick();
    total++;
    if (pc_a !== 32'h704) begin
      bad++; $display("FAIL flush_no_leftover pc=%h expected 00000704", pc_a);
    end
  endtask

  task automatic test_wrap();
    branch_flag = 1; branch_target = 32'hFFFFFFFC;
    tick();
    quiet();
    total++;
    if (pc_b !== 16'hFFFC || pc_a !== 32'hFFFFFFFC) begin
      bad++; $display("FAIL wrap_load pc16=%h pc32=%h expected fffc fffffffc", pc_b, pc_a);
    end
    tick();
    total++;
    if (pc_b !== 16'h0000 || pc_a !== 32'h0) begin
      bad++; $display("FAIL wrap_zero pc16=%h pc32=%h expected 0000 00000000", pc_b, pc_a);
    end
    tick();
    total++;
    if (pc_b !== 16'h0004 || pc_a !== 32'h4) begin
      bad++; $display("FAIL wrap_next pc16=%h pc32=%h expected 0004 00000004", pc_b, pc_a);
    end
  endtask

  task automatic test_reset_mid();
    stall_en = 6'b000001; branch_flag = 1; branch_target = 32'h7000;
    tick();
    branch_flag = 0; reset = 1;
    tick();
    total++;
    if (ce_a !== 1'b0 || pc_a !== RV || rp_a !== 1'b0 || pt_a !== 32'h0) begin
      bad++; $display("FAIL reset_mid ce=%b pc=%h rp=%b pt=%h expected 0 %h 0 0", ce_a, pc_a, rp_a, pt_a, RV);
    end
    reset = 0; stall_en = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (pc_a !== RV + 32'(4 * i) || rp_a !== 1'b0) begin
        bad++; $display("FAIL reset_mid_resume pc=%h rp=%b expected %h 0", pc_a, rp_a, RV + 32'(4 * i));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      stall_en = 6'($urandom);
      stall_en[0] = ($urandom_range(0, 99) < 40);
      branch_flag = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 8);
      branch_target = {$urandom} & ~32'h3;
      flush_target = {$urandom} & ~32'h3;
      if ($urandom_range(0, 9) == 0) branch_target = 32'hFFFFFFF8 + 32'($urandom_range(0, 1) * 4);
      tick();
      total++;
      if (ce_a !== m_en[0] || pc_a !== m_pc[0] || rp_a !== m_pend[0] || pt_a !== m_ptgt[0]) begin
        bad++; $display("FAIL random32 cyc=%0d ce=%b pc=%h rp=%b pt=%h expected %b %h %b %h",
                        i, ce_a, pc_a, rp_a, pt_a, m_en[0], m_pc[0], m_pend[0], m_ptgt[0]);
      end
      total++;
      if (ce_b !== m_en[1] || pc_b !== m_pc[1][15:0] || rp_b !== m_pend[1] || pt_b !== m_ptgt[1][15:0]) begin
        bad++; $display("FAIL random16 cyc=%0d ce=%b pc=%h rp=%b pt=%h expected %b %h %b %h",
                        i, ce_b, pc_b, rp_b, pt_b, m_en[1], m_pc[1][15:0], m_pend[1], m_ptgt[1][15:0]);
      end
    end
    reset = 0; quiet();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised fetch-stage program counter: a successor to the fixed 32-bit increment/stall PC.
- Generates the instruction-fetch address and the instruction-memory chip enable.
- Adds a configurable width, reset vector and step, branch/jump redirect, and pipeline flush (exception) redirect.
- Adds a one-entry pending-redirect buffer, so a branch resolved while fetch is stalled is not lost.

Parameters:
PC_W, 32, width of pc and of all target buses
RESET_VECTOR, 0, pc value held while chip_en is low (PC_W bits)
STEP, 4, byte increment per sequential fetch
STALL_W, 6, width of the pipeline stall vector; bit 0 is the PC stage

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_en  input  STALL_W  pipeline stall vector; only bit 0 affects this block
branch_flag  input  1  single-cycle pulse: redirect to branch_target
branch_target  input  PC_W  branch/jump destination, loaded verbatim
flush  input  1  single-cycle pulse: exception/flush redirect
flush_target  input  PC_W  exception handler / return address, loaded verbatim
chip_en  output  1  instruction-memory enable
pc  output  PC_W  current fetch address
redirect_pending  output  1  a buffered branch is waiting for the stall to clear
pending_target  output  PC_W  buffered branch destination (debug/visibility)

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- All outputs are registered; none are combinational from inputs.
- Reset (reset=1 at an edge):
  - chip_en<=0, pc<=RESET_VECTOR, redirect_pending<=0, pending_target<=0.
  - Reset asserted mid-stall or with a pending redirect discards all state the same way.
- chip_en:
  - <=0 while reset=1; <=1 at the first edge with reset=0.
  - One cycle of latency after reset release, matching the prior PC.
- While chip_en==0:
  - pc<=RESET_VECTOR and redirect_pending<=0.
  - branch_flag, flush and stall_en are ignored.
- While chip_en==1, the pc update at each edge uses this priority (highest first):
  1. flush=1: pc<=flush_target, redirect_pending<=0. This applies even when stall_en[0]=1, and any buffered branch is discarded.
  2. stall_en[0]=0 and branch_flag=1: pc<=branch_target, redirect_pending<=0. A live branch beats an older buffered one.
  3. stall_en[0]=0 and redirect_pending=1: pc<=pending_target, redirect_pending<=0.
  4. stall_en[0]=1 and branch_flag=1: pc holds, redirect_pending<=1, pending_target<=branch_target. A newer branch overwrites an existing buffer.
  5. stall_en[0]=1: pc holds; buffer unchanged.
  6. Otherwise: pc<=pc+STEP.
- Arithmetic: the increment is modulo 2^PC_W, so pc=2^PC_W-STEP wraps to 0 with no flag. Targets are not realigned.
- Redirect latency: a redirect input sampled at edge N is visible on pc after edge N (one cycle), unless deferred by rule 4.
- Deferred branch: it is applied at the first edge where stall_en[0]=0 and no flush or live branch is present.
- stall_en bits other than bit 0 are unused; they are kept for interface uniformity with the other pipeline stages.
- Simultaneous flush and branch_flag: flush wins; the branch is dropped and not buffered.

Test Plan:
- Reset/start-up (RESET_VECTOR=0xBFC00000):
  - Hold reset 3 cycles, then release.
  - Required: chip_en=0 and pc=0xBFC00000 during reset; chip_en=1 one edge after release.
  - Required: pc=0xBFC00000, then 0xBFC00004, then 0xBFC00008 on successive cycles.
- Stall hold:
  - At pc=0x100, assert stall_en=6'b000011 for 3 cycles.
  - Required: pc stays 0x100 for 3 cycles, then 0x104.
  - Also: stall_en=6'b111110 must not stall (pc keeps incrementing).
- Branch while running and while stalled:
  - branch_flag with target 0x2000, no stall → pc=0x2000 next cycle.
  - Repeat during stall_en[0]=1 → redirect_pending=1, pending_target=0x2000, pc held.
  - Release stall → pc=0x2000 and redirect_pending=0 next cycle.
  - Two branches (0x3000 then 0x4000) during one stall → 0x4000 is applied.
- Flush priority:
  - Pending branch to 0x2000, stall active; pulse flush with flush_target=0x80.
  - Required: pc=0x80 next cycle despite the stall, and redirect_pending=0.
  - Simultaneous flush and branch with no stall → pc=flush_target.
- Wrap-around (PC_W=16, STEP=4):
  - Branch to 0xFFFC.
  - Required: next pc=0x0000, then 0x0004.
- Reset mid-operation:
  - Assert reset while redirect_pending=1 and stalled.
  - Required: next edge gives chip_en=0, pc=RESET_VECTOR, redirect_pending=0.
  - After release, the old pending target is never loaded.
